// File: rtl/mio_pkg.sv
// Shared MIO address map, CTRL bit positions and I/O decode helper.
package mio_pkg;

  localparam logic [31:0] ADDR_LED  = 32'hE000_0000;
  localparam logic [31:0] ADDR_SW   = 32'hE000_0004;
  localparam logic [31:0] ADDR_CNT  = 32'hE000_0008;
  localparam logic [31:0] ADDR_CMP  = 32'hE000_000C;
  localparam logic [31:0] ADDR_CTRL = 32'hE000_0010;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_PEND = 1;
  localparam int unsigned CTRL_ERR  = 2;
  localparam int unsigned CTRL_IE   = 3;

  typedef enum logic [2:0] {
    SEL_NONE, SEL_RAM, SEL_LED, SEL_SW, SEL_CNT, SEL_CMP, SEL_CTRL
  } sel_e;

  // Word-aligned match against the memory-mapped I/O registers.
  function automatic sel_e io_sel(input logic [29:0] word);
    sel_e s;
    s = SEL_NONE;
    if (word == ADDR_LED[31:2])  s = SEL_LED;
    if (word == ADDR_SW[31:2])   s = SEL_SW;
    if (word == ADDR_CNT[31:2])  s = SEL_CNT;
    if (word == ADDR_CMP[31:2])  s = SEL_CMP;
    if (word == ADDR_CTRL[31:2]) s = SEL_CTRL;
    return s;
  endfunction

endpackage

// File: rtl/mio_timer.sv
// Free-running compare timer: CNT/CMP registers, EN/IE/PEND control bits and irq.
module mio_timer
  import mio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cnt_we,
  input  logic        cmp_we,
  input  logic        ctrl_we,
  input  logic [31:0] wdata,
  output logic [31:0] cnt,
  output logic [31:0] cmp,
  output logic        en,
  output logic        ie,
  output logic        pend,
  output logic        irq
);

  logic        match;
  logic [31:0] cnt_n;
  logic [31:0] cmp_n;
  logic        en_n;
  logic        ie_n;
  logic        pend_n;

  // Next-state: a CPU write to CNT overrides counting, but a match seen this cycle still sets PEND.
  always_comb begin
    match  = en && (cnt == cmp);
    cnt_n  = cnt;
    cmp_n  = cmp;
    en_n   = en;
    ie_n   = ie;
    pend_n = pend;
    if (en) cnt_n = match ? 32'd0 : cnt + 32'd1;
    if (cnt_we) cnt_n = wdata;
    if (cmp_we) cmp_n = wdata;
    if (ctrl_we) begin
      en_n = wdata[CTRL_EN];
      ie_n = wdata[CTRL_IE];
      if (wdata[CTRL_PEND]) pend_n = 1'b0;
    end
    if (match) pend_n = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= 32'd0;
      cmp  <= 32'hFFFF_FFFF;
      en   <= 1'b0;
      ie   <= 1'b0;
      pend <= 1'b0;
      irq  <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      cmp  <= cmp_n;
      en   <= en_n;
      ie   <= ie_n;
      pend <= pend_n;
      irq  <= pend_n & ie_n;
    end
  end

endmodule

// File: rtl/mio_bus_resp.sv
// CPU memory-stage responder: data RAM, LED/switch I/O, timer and sticky bus-error flag.
module mio_bus_resp
  import mio_pkg::*;
#(
  parameter int unsigned RAM_AW = 10,
  parameter int unsigned LED_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  output logic [31:0]      rdata,
  output logic             ready,
  input  logic [LED_W-1:0] sw_in,
  output logic [LED_W-1:0] led_out,
  output logic             irq
);

  localparam int unsigned RAM_WORDS = 1 << RAM_AW;

  sel_e              sel;
  logic [31:0]       mem [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic [LED_W-1:0]  sw_s1;
  logic [LED_W-1:0]  sw_s2;
  logic              err;
  logic              rdy_q;
  logic [31:0]       cnt;
  logic [31:0]       cmp;
  logic              en;
  logic              ie;
  logic              pend;
  logic              unused_addr;

  assign unused_addr = &{1'b0, addr[1:0]};
  assign ram_idx     = addr[RAM_AW+1:2];

  always_comb begin
    if ((addr >> (RAM_AW + 2)) == 32'd0) sel = SEL_RAM;
    else                                 sel = io_sel(addr[31:2]);
  end

  // RAM is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we && sel == SEL_RAM) mem[ram_idx] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_out <= '0;
      sw_s1   <= '0;
      sw_s2   <= '0;
      err     <= 1'b0;
      rdy_q   <= 1'b0;
      ready   <= 1'b0;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
      rdy_q <= 1'b1;
      ready <= rdy_q;
      if (we && sel == SEL_LED) led_out <= wdata[LED_W-1:0];
      if (we && sel == SEL_NONE)                        err <= 1'b1;
      else if (we && sel == SEL_CTRL && wdata[CTRL_ERR]) err <= 1'b0;
    end
  end

  mio_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .cnt_we  (we && sel == SEL_CNT),
    .cmp_we  (we && sel == SEL_CMP),
    .ctrl_we (we && sel == SEL_CTRL),
    .wdata   (wdata),
    .cnt     (cnt),
    .cmp     (cmp),
    .en      (en),
    .ie      (ie),
    .pend    (pend),
    .irq     (irq)
  );

  // Load data is combinational so the CPU can capture it at the MEM/WB edge.
  always_comb begin
    rdata = 32'd0;
    case (sel)
      SEL_RAM:  rdata = mem[ram_idx];
      SEL_LED:  rdata = 32'(led_out);
      SEL_SW:   rdata = 32'(sw_s2);
      SEL_CNT:  rdata = cnt;
      SEL_CMP:  rdata = cmp;
      SEL_CTRL: rdata = {28'd0, ie, err, pend, en};
      default:  rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mio_bus_resp.sv
// Randomized self-checking bench for mio_bus_resp against a behavioural model.
module tb_mio_bus_resp;

  localparam logic [31:0] A_LED  = 32'hE000_0000;
  localparam logic [31:0] A_SW   = 32'hE000_0004;
  localparam logic [31:0] A_CNT  = 32'hE000_0008;
  localparam logic [31:0] A_CMP  = 32'hE000_000C;
  localparam logic [31:0] A_CTRL = 32'hE000_0010;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        ready;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        irq;

  int checks;
  int failures;

  mio_bus_resp #(.RAM_AW(10), .LED_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata),
    .ready   (ready),
    .sw_in   (sw_in),
    .led_out (led_out),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; we = 1'b0;
    #1;
    d = rdata;
  endtask

  task automatic stop_timer();
    wr(A_CTRL, 32'h2);
    wr(A_CTRL, 32'h2);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0; addr = 32'd0; wdata = 32'd0; we = 1'b0; sw_in = 16'd0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", ready); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0b exp=0", irq); end
    checks++; if (led_out !== 16'd0) begin failures++; $display("FAIL reset_led got=%h exp=0", led_out); end
    rd(A_CNT, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", v); end
    rd(A_CMP, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp got=%h exp=ffffffff", v); end
    rd(A_CTRL, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", v); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ready_edge1 got=%0b exp=0", ready); end
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL ready_edge2 got=%0b exp=1", ready); end
  endtask

  task automatic test_ram();
    logic [31:0] v;
    logic [31:0] ram_m [int];
    int idx;
    wr(32'h14, 32'h5555_AAAA);
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, v);
    checks++; if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_0x10 got=%h exp=deadbeef", v); end
    rd(32'h14, v);
    checks++; if (v !== 32'h5555_AAAA) begin failures++; $display("FAIL ram_0x14 got=%h exp=5555aaaa", v); end
    for (int i = 0; i < 16; i++) begin
      idx = int'($urandom_range(0, 1023));
      ram_m[idx] = $urandom;
      wr(32'(idx) << 2 | 32'($urandom_range(0, 3)), ram_m[idx]);
    end
    foreach (ram_m[k]) begin
      rd(32'(k) << 2, v);
      checks++; if (v !== ram_m[k]) begin failures++; $display("FAIL ram_rand idx=%0d got=%h exp=%h", k, v, ram_m[k]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_led_sw();
    logic [31:0] v;
    logic [15:0] nsw;
    wr(A_LED, 32'h0000_00A5);
    checks++; if (led_out !== 16'h00A5) begin failures++; $display("FAIL led_write got=%h exp=00a5", led_out); end
    wr(A_SW, 32'hFFFF_FFFF);
    checks++; if (led_out !== 16'h00A5) begin failures++; $display("FAIL sw_write_led got=%h exp=00a5", led_out); end
    rd(A_CTRL, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL sw_write_ctrl got=%h exp=0", v); end
    for (int i = 0; i < 4; i++) begin
      nsw = (i == 0) ? 16'h1234 : 16'($urandom);
      v = 32'(sw_in);
      sw_in = nsw;
      @(posedge clk); #1;
      rd(A_SW, v);
      checks++; if (v[15:0] === nsw && nsw !== 16'(v)) begin failures++; end
      @(posedge clk); #1;
      rd(A_SW, v);
      checks++; if (v !== 32'(nsw)) begin failures++; $display("FAIL sw_sync got=%h exp=%h", v, nsw); end
    end
  endtask

  // Counting from 0 with compare c: CNT(k) = k mod (c+1), PEND once k > c.
  task automatic test_timer();
    logic [31:0] v;
    int unsigned c;
    int unsigned kmax;
    logic pexp;
    for (int t = 0; t < 3; t++) begin
      c = (t == 0) ? 3 : $urandom_range(2, 6);
      stop_timer();
      wr(A_CNT, 32'd0);
      wr(A_CMP, 32'(c));
      wr(A_CTRL, 32'h9);
      kmax = 2 * c + 3;
      for (int unsigned k = 0; k <= kmax; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        pexp = (k >= c + 1);
        rd(A_CNT, v);
        checks++; if (v !== 32'(k % (c + 1))) begin failures++; $display("FAIL cnt c=%0d k=%0d got=%0d exp=%0d", c, k, v, k % (c + 1)); end
        rd(A_CTRL, v);
        checks++; if (v !== (32'h9 | (32'(pexp) << 1))) begin failures++; $display("FAIL ctrl c=%0d k=%0d got=%h exp=%h", c, k, v, 32'h9 | (32'(pexp) << 1)); end
        checks++; if (irq !== pexp) begin failures++; $display("FAIL irq c=%0d k=%0d got=%0b exp=%0b", c, k, irq, pexp); end
      end
      // Clear coinciding with a match: set wins.
      stop_timer();
      wr(A_CNT, 32'(c));
      wr(A_CTRL, 32'h9);
      wr(A_CTRL, 32'hB);
      rd(A_CTRL, v);
      checks++; if (v !== 32'hB || irq !== 1'b1) begin failures++; $display("FAIL clr_vs_match ctrl=%h irq=%0b exp ctrl=b irq=1", v, irq); end
      wr(A_CTRL, 32'hB);
      rd(A_CTRL, v);
      checks++; if (v !== 32'h9 || irq !== 1'b0) begin failures++; $display("FAIL pend_clear ctrl=%h irq=%0b exp ctrl=9 irq=0", v, irq); end
      rd(A_CNT, v);
      checks++; if (v !== 32'd1) begin failures++; $display("FAIL cnt_after_clear got=%0d exp=1", v); end
      // CNT write during a match: load wins for CNT, PEND still sets.
      stop_timer();
      wr(A_CNT, 32'(c));
      wr(A_CTRL, 32'h9);
      wr(A_CNT, 32'h100);
      rd(A_CNT, v);
      checks++; if (v !== 32'h100) begin failures++; $display("FAIL cnt_load_match got=%h exp=100", v); end
      rd(A_CTRL, v);
      checks++; if (v !== 32'hB) begin failures++; $display("FAIL pend_load_match got=%h exp=b", v); end
    end
    stop_timer();
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    for (int t = 0; t < 2; t++) begin
      stop_timer();
      wr(A_CMP, (t == 0) ? 32'd5 : 32'hFFFF_FFFF);
      wr(A_CNT, 32'hFFFF_FFFE);
      wr(A_CTRL, 32'h1);
      @(posedge clk); #1;
      rd(A_CNT, v);
      checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_ff t=%0d got=%h exp=ffffffff", t, v); end
      @(posedge clk); #1;
      rd(A_CNT, v);
      checks++; if (v !== 32'd0) begin failures++; $display("FAIL wrap_0 t=%0d got=%h exp=0", t, v); end
      rd(A_CTRL, v);
      checks++; if (v !== ((t == 0) ? 32'h1 : 32'h3)) begin failures++; $display("FAIL wrap_pend t=%0d got=%h exp=%h", t, v, (t == 0) ? 32'h1 : 32'h3); end
    end
    stop_timer();
  endtask

  task automatic test_err();
    logic [31:0] v;
    wr(32'hE000_0020, $urandom);
    rd(A_CTRL, v);
    checks++; if (v !== 32'h4) begin failures++; $display("FAIL err_set got=%h exp=4", v); end
    rd(32'hE000_0020, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL unmapped_rd got=%h exp=0", v); end
    rd(32'h2000_0000, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL beyond_ram_rd got=%h exp=0", v); end
    wr(A_CTRL, 32'h4);
    rd(A_CTRL, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL err_clear got=%h exp=0", v); end
    addr = 32'hE000_0020; we = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rd(A_CTRL, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL unmapped_read_err got=%h exp=0", v); end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    stop_timer();
    wr(A_CMP, 32'd1);
    wr(A_CNT, 32'd0);
    wr(A_CTRL, 32'h9);
    @(posedge clk); @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq got=%0b exp=1", irq); end
    addr = A_CNT;
    #2 reset = 1'b0;
    #1;
    checks++; if (irq !== 1'b0 || ready !== 1'b0) begin failures++; $display("FAIL async_irq_ready irq=%0b ready=%0b exp 0 0", irq, ready); end
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL async_cnt got=%h exp=0", rdata); end
    rd(A_CTRL, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL async_ctrl got=%h exp=0", v); end
    checks++; if (led_out !== 16'd0) begin failures++; $display("FAIL async_led got=%h exp=0", led_out); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rerelease_edge1 got=%0b exp=0", ready); end
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rerelease_edge2 got=%0b exp=1", ready); end
    rd(A_CNT, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL cnt_stopped got=%h exp=0", v); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_ram();
    test_led_sw();
    test_timer();
    test_wrap();
    test_err();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
